mcp3202_spi_responder: RTL and testbench

Synthesizable SPI responder that emulates the MCP3202 12-bit ADC at the chip-side end of the link. It answers MCP3202-format transactions from an SPI initiator (our SPI-to-AXIS ADC master) using sample values supplied over an AXI-Stream input. It is used for hardware-in-the-loop bring-up of the SPI-to-DMA path and for loopback tests on the FPGA without the physical ADC fitted.

---
 rtl/mcp3202_spi_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_mcp3202_spi_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3202_spi_responder.sv
// MCP3202 ADC emulator on the chip side of an SPI link. Sample values arrive over AXI-Stream
// and are returned to the SPI initiator in MCP3202 transaction format.
module mcp3202_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] INIT_CH0    = 12'h800,
  parameter logic [11:0] INIT_CH1    = 12'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        conv_done,
  output logic        abort,
  output logic        cfg_sgl,
  output logic        cfg_odd
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_GET_SGL    = 4'd2,
    ST_GET_ODD    = 4'd3,
    ST_GET_MSBF   = 4'd4,
    ST_NULL       = 4'd5,
    ST_DATA_MSB   = 4'd6,
    ST_DATA_LSB   = 4'd7,
    ST_TRAIL      = 4'd8
  } state_t;

  logic [SS-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic          sck_prev_q;
  logic [11:0]   ch0_q, ch1_q;
  logic          tready_q;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [11:0]   tx_word_q, tx_word_d;
  logic          sgl_q, sgl_d, msbf_q, msbf_d;
  logic          b0_sent_q, b0_sent_d, done_q, done_d;
  logic          miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic          conv_done_q, conv_done_d, abort_q, abort_d;
  logic          cfg_sgl_q, cfg_sgl_d, cfg_odd_q, cfg_odd_d;
  logic          cs_s, mosi_s, sck_rise_s, sck_fall_s;
  logic          tdata_unused;

  assign cs_s       = cs_sync_q[SS-1];
  assign mosi_s     = mosi_sync_q[SS-1];
  assign sck_rise_s = sck_sync_q[SS-1] & ~sck_prev_q;
  assign sck_fall_s = ~sck_sync_q[SS-1] & sck_prev_q;
  assign tdata_unused = ^s_axis_tdata[15:13];

  // Pin synchronizers; reset leaves the link looking idle (cs high, sck low).
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= {SS{1'b1}};
      sck_sync_q  <= {SS{1'b0}};
      mosi_sync_q <= {SS{1'b0}};
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SS-2:0], cs};
      sck_sync_q  <= {sck_sync_q[SS-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SS-2:0], mosi};
      sck_prev_q  <= sck_sync_q[SS-1];
    end
  end

  // Channel holding registers fed from the AXI-Stream side.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch0_q    <= INIT_CH0;
      ch1_q    <= INIT_CH1;
      tready_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (s_axis_tvalid && tready_q) begin
        if (s_axis_tdata[12]) ch1_q <= s_axis_tdata[11:0];
        else                  ch0_q <= s_axis_tdata[11:0];
      end
    end
  end

  // Transaction state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      tx_word_q   <= 12'h000;
      sgl_q       <= 1'b0;
      msbf_q      <= 1'b0;
      b0_sent_q   <= 1'b0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      conv_done_q <= 1'b0;
      abort_q     <= 1'b0;
      cfg_sgl_q   <= 1'b0;
      cfg_odd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_word_q   <= tx_word_d;
      sgl_q       <= sgl_d;
      msbf_q      <= msbf_d;
      b0_sent_q   <= b0_sent_d;
      done_q      <= done_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      conv_done_q <= conv_done_d;
      abort_q     <= abort_d;
      cfg_sgl_q   <= cfg_sgl_d;
      cfg_odd_q   <= cfg_odd_d;
    end
  end

  // Next-state logic: command bits on sck rises, response bits on sck falls.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_word_d   = tx_word_q;
    sgl_d       = sgl_q;
    msbf_d      = msbf_q;
    b0_sent_d   = b0_sent_q;
    done_d      = done_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    conv_done_d = 1'b0;
    abort_d     = 1'b0;
    cfg_sgl_d   = cfg_sgl_q;
    cfg_odd_d   = cfg_odd_q;
    if (cs_s) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      if ((state_q != ST_IDLE) && (state_q != ST_WAIT_START) && !done_q) abort_d = 1'b1;
      else                                                               abort_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_WAIT_START;
          done_d    = 1'b0;
          b0_sent_d = 1'b0;
        end
        ST_WAIT_START: begin
          if (sck_rise_s && mosi_s) state_d = ST_GET_SGL;
          else                      state_d = ST_WAIT_START;
        end
        ST_GET_SGL: begin
          if (sck_rise_s) begin
            sgl_d   = mosi_s;
            state_d = ST_GET_ODD;
          end else begin
            state_d = ST_GET_SGL;
          end
        end
        ST_GET_ODD: begin
          // Holding registers are sampled before any same-cycle AXIS write lands.
          if (sck_rise_s) begin
            tx_word_d = mosi_s ? ch1_q : ch0_q;
            cfg_sgl_d = sgl_q;
            cfg_odd_d = mosi_s;
            state_d   = ST_GET_MSBF;
          end else begin
            state_d = ST_GET_ODD;
          end
        end
        ST_GET_MSBF: begin
          if (sck_rise_s) begin
            msbf_d  = mosi_s;
            state_d = ST_NULL;
          end else begin
            state_d = ST_GET_MSBF;
          end
        end
        ST_NULL: begin
          if (sck_fall_s) begin
            miso_oe_d = 1'b1;
            miso_d    = 1'b0;
            idx_d     = 4'd11;
            state_d   = ST_DATA_MSB;
          end else begin
            state_d = ST_NULL;
          end
        end
        ST_DATA_MSB: begin
          // B0 is shared: the fall after it either ends the word or starts the LSB-first copy at B1.
          if (sck_fall_s && b0_sent_q) begin
            conv_done_d = 1'b1;
            done_d      = 1'b1;
            if (msbf_q) begin
              miso_d  = 1'b0;
              state_d = ST_TRAIL;
            end else begin
              miso_d  = tx_word_q[1];
              idx_d   = 4'd2;
              state_d = ST_DATA_LSB;
            end
          end else if (sck_fall_s) begin
            miso_d = tx_word_q[idx_q];
            if (idx_q == 4'd0) b0_sent_d = 1'b1;
            else               idx_d     = idx_q - 4'd1;
          end else begin
            state_d = ST_DATA_MSB;
          end
        end
        ST_DATA_LSB: begin
          if (sck_fall_s) begin
            miso_d = tx_word_q[idx_q];
            if (idx_q == 4'd11) state_d = ST_TRAIL;
            else                idx_d   = idx_q + 4'd1;
          end else begin
            state_d = ST_DATA_LSB;
          end
        end
        ST_TRAIL: begin
          if (sck_fall_s) miso_d = 1'b0;
          else            miso_d = miso_q;
        end
        default: begin
          state_d   = ST_IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = miso_oe_q;
  assign s_axis_tready = tready_q;
  assign conv_done     = conv_done_q;
  assign abort         = abort_q;
  assign cfg_sgl       = cfg_sgl_q;
  assign cfg_odd       = cfg_odd_q;

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Directed bench for mcp3202_spi_responder: bit-level SPI initiator at 100 MHz clk / 1 MHz SCK.
module tb_mcp3202_spi_responder;

  localparam int HALF = 50;
  localparam int SS   = 2;

  logic        clk = 1'b0;
  logic        rst, cs, sck, mosi;
  logic [15:0] tdata;
  logic        tvalid;
  logic        miso, miso_oe, tready, conv_done, abort, cfg_sgl, cfg_odd;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   d0, a0;
  logic rx    [0:39];
  logic oe_rx [0:39];

  always #5 clk = ~clk;

  mcp3202_spi_responder #(.SYNC_STAGES(SS), .INIT_CH0(12'h800), .INIT_CH1(12'h800)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .conv_done(conv_done), .abort(abort), .cfg_sgl(cfg_sgl), .cfg_odd(cfg_odd)
  );

  // Pulse counters (one count per clk the strobe is high).
  always @(posedge clk) begin
    if (conv_done === 1'b1) done_cnt <= done_cnt + 1;
    if (abort === 1'b1)     abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axis_write(input logic ch, input logic [11:0] v);
    tdata  = {3'b000, ch, v};
    tvalid = 1'b1;
    tick(1);
    tvalid = 1'b0;
    tick(1);
  endtask

  task automatic sck_cycle(input logic mo, input bit wr, input logic [11:0] wv,
                           output logic mi, output logic oe);
    mosi = mo;
    tick(HALF);
    mi  = miso;
    oe  = miso_oe;
    sck = 1'b1;
    if (wr) begin
      // Lands the AXIS handshake on the same clk the responder latches ODD.
      tick(2);
      tdata  = {4'b0000, wv};
      tvalid = 1'b1;
      tick(1);
      tvalid = 1'b0;
      tick(HALF - 3);
    end else begin
      tick(HALF);
    end
    sck = 1'b0;
  endtask

  task automatic xfer(input int lead, input logic sgl, input logic odd, input logic msbf,
                      input int ncyc, input int wr_cyc, input logic [11:0] wv);
    logic mo;
    cs = 1'b0;
    tick(HALF);
    for (int i = 0; i < ncyc; i++) begin
      if (i < lead)           mo = 1'b0;
      else if (i == lead)     mo = 1'b1;
      else if (i == lead + 1) mo = sgl;
      else if (i == lead + 2) mo = odd;
      else if (i == lead + 3) mo = msbf;
      else                    mo = 1'b0;
      sck_cycle(mo, (i == wr_cyc), wv, rx[i], oe_rx[i]);
    end
    tick(HALF);
    cs = 1'b1;
  endtask

  function automatic logic [11:0] msb_word(input int base);
    logic [11:0] w;
    for (int k = 0; k < 12; k++) w[11-k] = rx[base+k];
    return w;
  endfunction

  function automatic logic [11:0] lsb_word(input int base);
    logic [11:0] w;
    w[0] = 1'b0;
    for (int k = 0; k < 11; k++) w[k+1] = rx[base+k];
    return w;
  endfunction

  initial begin
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tdata = 16'h0000; tvalid = 1'b0;
    tick(3);
    check("rst_miso",   32'(miso),      32'd0);
    check("rst_oe",     32'(miso_oe),   32'd0);
    check("rst_tready", 32'(tready),    32'd0);
    check("rst_done",   32'(conv_done), 32'd0);
    check("rst_abort",  32'(abort),     32'd0);
    check("rst_cfg",    32'({cfg_sgl, cfg_odd}), 32'd0);
    rst = 1'b0;
    tick(2);
    check("tready_after_rst", 32'(tready), 32'd1);

    // 1: ch0 = A5C, SGL=1 ODD=0 MSBF=1
    axis_write(1'b0, 12'hA5C);
    d0 = done_cnt; a0 = abort_cnt;
    xfer(0, 1'b1, 1'b0, 1'b1, 20, -1, 12'h000);
    tick(SS + 2);
    check("t1_oe_after_cs", 32'(miso_oe), 32'd0);
    tick(6);
    check("t1_oe_before_null", 32'(oe_rx[3]), 32'd0);
    check("t1_null_oe",   32'(oe_rx[4]), 32'd1);
    check("t1_null_bit",  32'(rx[4]),    32'd0);
    check("t1_word",      32'(msb_word(5)), 32'hA5C);
    check("t1_trail",     32'({rx[17], rx[18], rx[19]}), 32'd0);
    check("t1_done_cnt",  32'(done_cnt - d0),  32'd1);
    check("t1_abort_cnt", 32'(abort_cnt - a0), 32'd0);
    check("t1_cfg",       32'({cfg_sgl, cfg_odd}), 32'b10);

    // 2: ch1 = 3F1, SGL=1 ODD=1 MSBF=0
    axis_write(1'b1, 12'h3F1);
    d0 = done_cnt;
    xfer(0, 1'b1, 1'b1, 1'b0, 31, -1, 12'h000);
    tick(10);
    check("t2_word_msb", 32'(msb_word(5)),  32'h3F1);
    check("t2_word_lsb", 32'(lsb_word(17)), 32'h3F0);
    check("t2_trail",    32'({rx[28], rx[29], rx[30]}), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t2_cfg",      32'({cfg_sgl, cfg_odd}), 32'b11);

    // 3: three leading zeros before the start bit
    d0 = done_cnt;
    xfer(3, 1'b1, 1'b0, 1'b1, 23, -1, 12'h000);
    tick(10);
    check("t3_pre_oe",   32'(oe_rx[6]), 32'd0);
    check("t3_null_oe",  32'(oe_rx[7]), 32'd1);
    check("t3_null_bit", 32'(rx[7]),    32'd0);
    check("t3_word",     32'(msb_word(8)), 32'hA5C);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t3_cfg",      32'({cfg_sgl, cfg_odd}), 32'b10);

    // 4: cs released after six data bits
    d0 = done_cnt; a0 = abort_cnt;
    xfer(0, 1'b1, 1'b0, 1'b1, 11, -1, 12'h000);
    tick(SS + 2);
    check("t4_oe_after_cs",   32'(miso_oe), 32'd0);
    check("t4_miso_after_cs", 32'(miso),    32'd0);
    tick(6);
    check("t4_partial",   32'({rx[5], rx[6], rx[7], rx[8], rx[9], rx[10]}), 32'b101001);
    check("t4_abort_cnt", 32'(abort_cnt - a0), 32'd1);
    check("t4_done_cnt",  32'(done_cnt - d0),  32'd0);
    check("t4_cfg_kept",  32'({cfg_sgl, cfg_odd}), 32'b10);
    d0 = done_cnt;
    xfer(0, 1'b1, 1'b0, 1'b1, 20, -1, 12'h000);
    tick(10);
    check("t4_next_word", 32'(msb_word(5)), 32'hA5C);
    check("t4_next_done", 32'(done_cnt - d0), 32'd1);

    // cs low with no start bit: nothing happens
    a0 = abort_cnt; d0 = done_cnt;
    xfer(10, 1'b0, 1'b1, 1'b0, 4, -1, 12'h000);
    tick(10);
    check("nostart_abort", 32'(abort_cnt - a0), 32'd0);
    check("nostart_done",  32'(done_cnt - d0),  32'd0);
    check("nostart_cfg",   32'({cfg_sgl, cfg_odd}), 32'b10);

    // 5: AXIS write coincident with the ODD latch
    axis_write(1'b0, 12'h001);
    xfer(0, 1'b1, 1'b0, 1'b1, 20, 2, 12'hFFF);
    tick(10);
    check("t5_old_word", 32'(msb_word(5)), 32'h001);
    xfer(0, 1'b1, 1'b0, 1'b1, 20, -1, 12'h000);
    tick(10);
    check("t5_new_word", 32'(msb_word(5)), 32'hFFF);
    check("t5_trail",    32'(rx[17]), 32'd0);

    // 6: reset in the middle of DATA_MSB
    d0 = done_cnt;
    cs = 1'b0;
    tick(HALF);
    for (int i = 0; i < 10; i++)
      sck_cycle((i < 2 || i == 3) ? 1'b1 : 1'b0, 1'b0, 12'h000, rx[i], oe_rx[i]);
    check("t6_oe_mid", 32'(miso_oe), 32'd1);
    rst = 1'b1;
    cs  = 1'b1;
    tick(2);
    check("t6_rst_miso",   32'(miso),    32'd0);
    check("t6_rst_oe",     32'(miso_oe), 32'd0);
    check("t6_rst_tready", 32'(tready),  32'd0);
    check("t6_rst_cfg",    32'({cfg_sgl, cfg_odd}), 32'd0);
    rst = 1'b0;
    a0 = abort_cnt;
    tick(4);
    check("t6_no_abort",  32'(abort_cnt - a0), 32'd0);
    check("t6_done_none", 32'(done_cnt - d0),  32'd0);
    xfer(0, 1'b1, 1'b0, 1'b1, 20, -1, 12'h000);
    tick(10);
    check("t6_word_init", 32'(msb_word(5)), 32'h800);
    check("t6_cfg",       32'({cfg_sgl, cfg_odd}), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
